// File: rtl/gr_heep_pkg.sv
// System-level constants for the gr-heep external crossbar.
// ExtXbarNSlave sets how many watchdog bridges sit on the external
// slave ports. ObiWdTimeoutCycles and ObiWdErrRdata are the default
// settings for each bridge instance.
package gr_heep_pkg;

  localparam int unsigned ExtXbarNSlave      = 2;
  localparam int unsigned ObiWdTimeoutCycles = 1024;
  localparam logic [31:0] ObiWdErrRdata      = 32'hBADC_AB1E;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus types shared by the external crossbar, its slaves and the
// watchdog bridge.
package obi_pkg;

  // Request channel: address phase plus write data.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  // Response channel: grant for the address phase, rvalid/rdata for the response phase.
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/gr_heep_obi_watchdog_bridge.sv
// OBI watchdog bridge. It allows one outstanding transaction between one
// external-xbar master port and one external slave.
// While the slave keeps up, req/gnt/rvalid pass through with no added
// latency. If the slave misses the gnt deadline or the rvalid deadline,
// the bridge completes the transaction upstream itself and returns
// ErrRdata. After an rvalid timeout it then swallows one late rvalid.
// Optional status block: define GR_HEEP_OBI_WD_STATUS_EN to add the
// wd_clear_i, wd_count_o and wd_last_addr_o ports.
module gr_heep_obi_watchdog_bridge
  import obi_pkg::*;
  import gr_heep_pkg::*;
#(
  parameter int unsigned TimeoutCycles = ObiWdTimeoutCycles,  // must be >= 2
  parameter logic [31:0] ErrRdata      = ObiWdErrRdata
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    slv_req_i,
  output obi_resp_t   slv_resp_o,
  output obi_req_t    mst_req_o,
  input  obi_resp_t   mst_resp_i,
  output logic        timeout_o
`ifdef GR_HEEP_OBI_WD_STATUS_EN
  ,
  input  logic        wd_clear_i,
  output logic [15:0] wd_count_o,
  output logic [31:0] wd_last_addr_o
`endif
);

  localparam int unsigned     CntW    = $clog2(TimeoutCycles) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RV,
    ERR_RV,
    DRAIN
  } obi_wd_state_e;

  obi_wd_state_e   r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_drain;
  logic [31:0]     r_addr;
  logic            w_timeout;

  assign w_timeout = (r_cnt == CntLast);

  // Transaction FSM, wait counter, drain flag and address latch.
  // NOTE: state uses non-blocking assignments so that every register in
  // this block samples the values from before the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_drain <= 1'b0;
      r_addr  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_drain <= 1'b0;
          if (slv_req_i.req) begin
            r_addr <= slv_req_i.addr;
            if (mst_resp_i.gnt) begin
              r_state <= WAIT_RV;
            end else begin
              // The request already stalled for one cycle in IDLE, so
              // the wait for gnt starts at 1.
              r_state <= WAIT_GNT;
              r_cnt   <= CntW'(1);
            end
          end
        end
        WAIT_GNT: begin
          // A gnt that arrives in the deadline cycle still wins.
          if (mst_resp_i.gnt) begin
            r_state <= WAIT_RV;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_state <= ERR_RV;
            r_cnt   <= '0;
            r_drain <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        WAIT_RV: begin
          if (mst_resp_i.rvalid) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            // The slave still owes an rvalid; remember to absorb it.
            r_state <= ERR_RV;
            r_cnt   <= '0;
            r_drain <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        ERR_RV: begin
          r_cnt   <= '0;
          r_drain <= 1'b0;
          // A late rvalid seen here is swallowed now, so nothing is left to drain.
          r_state <= (r_drain && !mst_resp_i.rvalid) ? DRAIN : IDLE;
        end
        DRAIN: begin
          // A second timeout here means the slave is dead; return to IDLE without reporting it.
          if (mst_resp_i.rvalid || w_timeout) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output steering: pass-through, stall or a locally generated error response.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    mst_req_o  = '0;
    slv_resp_o = '0;
    timeout_o  = 1'b0;
    unique case (r_state)
      IDLE: begin
        mst_req_o      = slv_req_i;
        slv_resp_o.gnt = mst_resp_i.gnt;
      end
      WAIT_GNT: begin
        mst_req_o = slv_req_i;
        if (!mst_resp_i.gnt && w_timeout) begin
          mst_req_o.req  = 1'b0;
          slv_resp_o.gnt = 1'b1;
          timeout_o      = 1'b1;
        end else begin
          slv_resp_o.gnt = mst_resp_i.gnt;
        end
      end
      WAIT_RV: begin
        slv_resp_o.rvalid = mst_resp_i.rvalid;
        if (mst_resp_i.rvalid) begin
          slv_resp_o.rdata = mst_resp_i.rdata;
        end
        timeout_o = !mst_resp_i.rvalid && w_timeout;
      end
      ERR_RV: begin
        slv_resp_o.rvalid = 1'b1;
        slv_resp_o.rdata  = ErrRdata;
      end
      default: ;  // DRAIN: both sides blocked
    endcase
  end

`ifdef GR_HEEP_OBI_WD_STATUS_EN
  logic [15:0] r_wd_count;
  logic [31:0] r_wd_last_addr;

  // Timeout statistics. A clear wins over an increment in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd_count     <= '0;
      r_wd_last_addr <= '0;
    end else if (wd_clear_i) begin
      r_wd_count     <= '0;
      r_wd_last_addr <= '0;
    end else if (timeout_o) begin
      if (r_wd_count != 16'hFFFF) begin
        r_wd_count <= r_wd_count + 16'd1;
      end
      r_wd_last_addr <= r_addr;
    end
  end

  assign wd_count_o     = r_wd_count;
  assign wd_last_addr_o = r_wd_last_addr;
`endif

endmodule

// File: tb/tb_gr_heep_obi_watchdog_bridge.sv
// Self-checking bench for gr_heep_obi_watchdog_bridge with TimeoutCycles=16.
// A cycle-by-cycle vector table covers plain pass-through traffic.
// Hand-written sequences cover the timeout, drain and reset corner cases.
// Every upstream rvalid pops the expected rdata from a scoreboard queue.
// The status checks are built in when GR_HEEP_OBI_WD_STATUS_EN is defined.
module tb_gr_heep_obi_watchdog_bridge;
  import obi_pkg::*;

  localparam int unsigned TO  = 16;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;

  logic      clk = 1'b0;
  logic      rst_ni = 1'b1;
  obi_req_t  slv_req;
  obi_resp_t slv_resp;
  obi_req_t  mst_req;
  obi_resp_t mst_resp;
  logic      timeout;
`ifdef GR_HEEP_OBI_WD_STATUS_EN
  logic        wd_clear;
  logic [15:0] wd_count;
  logic [31:0] wd_last_addr;
`endif

  always #5 clk = ~clk;

  gr_heep_obi_watchdog_bridge #(
    .TimeoutCycles(TO),
    .ErrRdata     (ERR)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp),
    .timeout_o (timeout)
`ifdef GR_HEEP_OBI_WD_STATUS_EN
    ,
    .wd_clear_i    (wd_clear),
    .wd_count_o    (wd_count),
    .wd_last_addr_o(wd_last_addr)
`endif
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb[$];
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic g, input logic rv,
                            input logic mreq, input logic to);
    check({tag, "_gnt"},     32'(slv_resp.gnt),    32'(g));
    check({tag, "_rvalid"},  32'(slv_resp.rvalid), 32'(rv));
    check({tag, "_mst_req"}, 32'(mst_req.req),     32'(mreq));
    check({tag, "_timeout"}, 32'(timeout),         32'(to));
  endtask

  // Drive one cycle of inputs just after posedge and return at the following negedge.
  task automatic cyc(input logic req, input logic we, input logic [31:0] addr,
                     input logic mgnt, input logic mrv, input logic [31:0] mrd);
    @(posedge clk);
    #1;
    slv_req.req     = req;
    slv_req.we      = we;
    slv_req.be      = 4'hF;
    slv_req.addr    = addr;
    slv_req.wdata   = ~addr;
    mst_resp.gnt    = mgnt;
    mst_resp.rvalid = mrv;
    mst_resp.rdata  = mrv ? mrd : 32'h0;
`ifdef GR_HEEP_OBI_WD_STATUS_EN
    wd_clear = 1'b0;
`endif
    @(negedge clk);
  endtask

  // Response monitor: each upstream rvalid must match the oldest expected rdata.
  always @(negedge clk) begin
    if (mon_en) begin
      if (slv_resp.rvalid) begin
        check("rvalid_was_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("rdata", slv_resp.rdata, sb.pop_front());
      end else begin
        check("rdata_zero_without_rvalid", slv_resp.rdata, 32'h0);
      end
    end
  end

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic        m_gnt;
    logic        m_rv;
    logic [31:0] m_rd;
    logic        e_gnt;
    logic        e_rv;
    logic        e_mreq;
    logic        e_to;
    logic        push;
    logic [31:0] push_d;
  } vec_t;

  function automatic vec_t mk(logic req, logic we, logic [31:0] addr, logic m_gnt,
                              logic m_rv, logic [31:0] m_rd, logic e_gnt, logic e_rv,
                              logic e_mreq, logic e_to, logic push, logic [31:0] push_d);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.m_gnt = m_gnt; v.m_rv = m_rv; v.m_rd = m_rd;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_mreq = e_mreq; v.e_to = e_to;
    v.push = push; v.push_d = push_d;
    return v;
  endfunction

`ifdef GR_HEEP_OBI_WD_STATUS_EN
  // Write request that the slave never grants. The bridge times it out in cycle 15.
  task automatic gnt_timeout(input logic [31:0] addr, input logic clr);
    cyc(1'b1, 1'b1, addr, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k < 15; k++) cyc(1'b1, 1'b1, addr, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    wd_clear = clr;
    @(negedge clk);
    check("g_timeout_pulse", 32'(timeout), 32'd1);
    sb.push_back(ERR);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("g_err_rvalid", 32'(slv_resp.rvalid), 32'd1);
  endtask
`endif

  vec_t vecs[$];

  initial begin
    slv_req  = '0;
    mst_resp = '0;
`ifdef GR_HEEP_OBI_WD_STATUS_EN
    wd_clear = 1'b0;
`endif
    #1 rst_ni = 1'b0;
    #1;
    check("reset_resp",    32'({slv_resp.gnt, slv_resp.rvalid}), 32'd0);
    check("reset_rdata",   slv_resp.rdata, 32'h0);
    check("reset_mst_req", 32'(mst_req.req), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
`ifdef GR_HEEP_OBI_WD_STATUS_EN
    check("reset_wd_count", 32'(wd_count), 32'd0);
    check("reset_wd_addr",  wd_last_addr, 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Read: gnt in the request cycle, rvalid three cycles later.
    vecs.push_back(mk(1, 0, 32'h0000_0100, 1, 0, 32'h0,         1, 0, 1, 0, 1, 32'h1234_5678));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h1234_5678, 0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0));
    // Back-to-back reads with rvalid 2 cycles after each gnt. Requests wait while one is outstanding.
    vecs.push_back(mk(1, 0, 32'h0000_0200, 1, 0, 32'h0,         1, 0, 1, 0, 1, 32'hA1A1_0001));
    vecs.push_back(mk(1, 0, 32'h0000_0204, 1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0000_0204, 1, 1, 32'hA1A1_0001, 0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0000_0204, 1, 0, 32'h0,         1, 0, 1, 0, 1, 32'hA1A1_0002));
    vecs.push_back(mk(1, 0, 32'h0000_0208, 1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0000_0208, 1, 1, 32'hA1A1_0002, 0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0000_0208, 1, 0, 32'h0,         1, 0, 1, 0, 1, 32'hA1A1_0003));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'hA1A1_0003, 0, 1, 0, 0, 0, 32'h0));
    // A stray rvalid in IDLE must not reach upstream.
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'hFFFF_0000, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0));

    foreach (vecs[i]) begin
      cyc(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].m_gnt, vecs[i].m_rv, vecs[i].m_rd);
      check_outs($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_rv, vecs[i].e_mreq, vecs[i].e_to);
      if (vecs[i].e_mreq) check($sformatf("vec%0d_addr", i), mst_req.addr, vecs[i].addr);
      if (vecs[i].push) sb.push_back(vecs[i].push_d);
    end

    // Write granted in cycle 15, after 15 stall cycles: normal completion, no timeout.
    cyc(1, 1, 32'h0000_0300, 0, 0, 32'h0);
    check_outs("w15_c0", 0, 0, 1, 0);
    for (int k = 1; k < 15; k++) begin
      cyc(1, 1, 32'h0000_0300, 0, 0, 32'h0);
      check($sformatf("w15_c%0d_timeout", k), 32'(timeout), 32'd0);
      check($sformatf("w15_c%0d_gnt", k), 32'(slv_resp.gnt), 32'd0);
    end
    cyc(1, 1, 32'h0000_0300, 1, 0, 32'h0);
    check_outs("w15_gnt", 1, 0, 1, 0);
    sb.push_back(32'h0000_0000);
    cyc(0, 0, 32'h0, 0, 1, 32'h0);
    check_outs("w15_rv", 0, 1, 0, 0);

    // Write never granted (16+ stall cycles): forced gnt with timeout in cycle 15, error rvalid in cycle 16.
    cyc(1, 1, 32'h0000_0400, 0, 0, 32'h0);
    check_outs("w16_c0", 0, 0, 1, 0);
    for (int k = 1; k < 15; k++) begin
      cyc(1, 1, 32'h0000_0400, 0, 0, 32'h0);
      check($sformatf("w16_c%0d_timeout", k), 32'(timeout), 32'd0);
    end
    cyc(1, 1, 32'h0000_0400, 0, 0, 32'h0);
    check_outs("w16_to", 1, 0, 0, 1);
    sb.push_back(ERR);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    check_outs("w16_err", 0, 1, 0, 0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    check_outs("w16_idle", 0, 0, 0, 0);

    // Read granted but never answered: timeout in cycle 16, error rvalid in cycle 17, late rvalid in cycle 20 swallowed.
    cyc(1, 0, 32'h0000_0500, 1, 0, 32'h0);
    check_outs("rd_gnt", 1, 0, 1, 0);
    sb.push_back(ERR);
    for (int k = 1; k < 16; k++) begin
      cyc(0, 0, 32'h0, 0, 0, 32'h0);
      check($sformatf("rd_c%0d_timeout", k), 32'(timeout), 32'd0);
    end
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    check_outs("rd_to", 0, 0, 0, 1);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    check_outs("rd_err", 0, 1, 0, 0);
    for (int k = 18; k < 20; k++) begin
      cyc(1, 0, 32'h0000_0600, 1, 0, 32'h0);
      check_outs($sformatf("rd_drain%0d", k), 0, 0, 0, 0);
    end
    cyc(0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    check_outs("rd_late_rv", 0, 0, 0, 0);
    for (int k = 21; k < 24; k++) begin
      cyc(0, 0, 32'h0, 0, 0, 32'h0);
      check_outs($sformatf("rd_after%0d", k), 0, 0, 0, 0);
    end

    // Asynchronous reset while waiting for rvalid. The aborted read gets no response.
    cyc(1, 0, 32'h0000_0700, 1, 0, 32'h0);
    check_outs("rst_gnt", 1, 0, 1, 0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    check_outs("rst_wait", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    mon_en          = 1'b0;
    mst_resp.rvalid = 1'b1;
    mst_resp.rdata  = 32'h5555_AAAA;
    rst_ni          = 1'b0;
    #1;
    check("rst_rvalid",  32'(slv_resp.rvalid), 32'd0);
    check("rst_rdata",   slv_resp.rdata, 32'h0);
    check("rst_gnt_low", 32'(slv_resp.gnt), 32'd0);
    check("rst_mst_req", 32'(mst_req.req), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    mst_resp = '0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    cyc(1, 0, 32'h0000_0800, 1, 0, 32'h0);
    check_outs("post_rst_gnt", 1, 0, 1, 0);
    sb.push_back(32'hC0FF_EE00);
    cyc(0, 0, 32'h0, 0, 1, 32'hC0FF_EE00);
    check_outs("post_rst_rv", 0, 1, 0, 0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);

`ifdef GR_HEEP_OBI_WD_STATUS_EN
    // Three counted timeouts, then a clear in the same cycle as a fourth.
    gnt_timeout(32'h0000_0A00, 1'b0);
    gnt_timeout(32'h0000_0B00, 1'b0);
    gnt_timeout(32'h0000_0C00, 1'b0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    check("wd_count_3", 32'(wd_count), 32'd3);
    check("wd_last_addr_3", wd_last_addr, 32'h0000_0C00);
    gnt_timeout(32'h0000_0D00, 1'b1);
    check("wd_count_cleared", 32'(wd_count), 32'd0);
    check("wd_last_addr_cleared", wd_last_addr, 32'h0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "time limit");
  end

endmodule
